// File: rtl/mra_pkg.sv
// Shared defaults, table entry type and helpers for mem_req_arbiter_n.
// Optional MRA_PRIO_EN gives channel 0 strict priority.
package mra_pkg;

    localparam int MRA_N_CH      = 5;
    localparam int MRA_ADDR_W    = 32;
    localparam int MRA_DATA_W    = 512;
    localparam int MRA_TAG_W     = 4;
    localparam int MRA_MAX_OUTST = 8;
    localparam int MRA_SRC_W     = $clog2(MRA_N_CH);
    localparam int MRA_VEC_W     = 64;

    typedef struct packed {
        logic                 vld;
        logic [MRA_SRC_W-1:0] src;
        logic [MRA_TAG_W-1:0] tag;
    } mra_entry_t;

    // Index of the lowest set bit, 0 when none is set.
    function automatic int unsigned first_free(input logic [MRA_VEC_W-1:0] v);
        first_free = 0;
        for (int i = MRA_VEC_W - 1; i >= 0; i--) begin
            if (v[i]) first_free = i;
        end
    endfunction

endpackage

// File: rtl/mem_req_arbiter_n_rr_arbiter.sv
// Rotating-pointer arbiter; prio_mask requesters win outright and
// do not move the pointer.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [N-1:0]  prio_mask,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  hi, lo;
    logic          found, hit;
    int            j;

    always_comb begin
        hi      = req & prio_mask;
        lo      = req & ~prio_mask;
        gnt_idx = '0;
        found   = 1'b0;
        hit     = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            if (!found && hi[i]) begin
                found   = 1'b1;
                hit     = 1'b1;
                gnt_idx = IW'(i);
            end
        end
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_q) + k;
            if (j >= N) j = j - N;
            if (!found && lo[j]) begin
                found   = 1'b1;
                gnt_idx = IW'(j);
            end
        end
        gnt = found ? (N'(1) << gnt_idx) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en && found && !hit) begin
            ptr_d = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_req_arbiter_n.sv
// N-channel memory request arbiter with in-flight tag table.
// Define MRA_PRIO_EN to give channel 0 strict priority.
module mem_req_arbiter_n
    import mra_pkg::*;
#(
    parameter  int N_CH      = MRA_N_CH,
    parameter  int ADDR_W    = MRA_ADDR_W,
    parameter  int DATA_W    = MRA_DATA_W,
    parameter  int TAG_W     = MRA_TAG_W,
    parameter  int MAX_OUTST = MRA_MAX_OUTST,
    localparam int ID_W      = $clog2(MAX_OUTST),
    localparam int SRC_W     = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          ch_req_valid,
    output logic [N_CH-1:0]          ch_req_ready,
    input  logic [N_CH-1:0]          ch_req_we,
    input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_req_wdata,
    input  logic [N_CH*TAG_W-1:0]    ch_req_tag,
    output logic [N_CH-1:0]          ch_rsp_valid,
    input  logic [N_CH-1:0]          ch_rsp_ready,
    output logic [TAG_W-1:0]         ch_rsp_tag,
    output logic [DATA_W-1:0]        ch_rsp_data,
    output logic                     rtr_req_valid,
    input  logic                     rtr_req_ready,
    output logic                     rtr_req_we,
    output logic [ADDR_W-1:0]        rtr_req_addr,
    output logic [DATA_W-1:0]        rtr_req_wdata,
    output logic [ID_W-1:0]          rtr_req_id,
    input  logic                     rtr_rsp_valid,
    output logic                     rtr_rsp_ready,
    input  logic [ID_W-1:0]          rtr_rsp_id,
    input  logic [DATA_W-1:0]        rtr_rsp_data,
    output logic                     err_bad_id
);

    typedef struct packed {
        logic             vld;
        logic [SRC_W-1:0] src;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t              tbl_q [MAX_OUTST];
    entry_t              tbl_d [MAX_OUTST];
    entry_t              rsp_ent;
    logic [MAX_OUTST-1:0] free_vec;
    logic [ID_W-1:0]     slot;
    logic                req_v_q, we_q, err_q, err_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ID_W-1:0]     id_q;
    logic                open, can_gnt, req_hs;
    logic                rsp_hit, rsp_bad, rsp_hs;
    logic [N_CH-1:0]     gnt, prio_mask;
    logic [SRC_W-1:0]    win;

`ifdef MRA_PRIO_EN
    assign prio_mask = N_CH'(1);
`else
    assign prio_mask = '0;
`endif

    // Free slots come from registered state only, so a slot released
    // this cycle is first reusable next cycle.
    always_comb begin
        for (int s = 0; s < MAX_OUTST; s++) begin
            free_vec[s] = !tbl_q[s].vld;
        end
        slot    = ID_W'(first_free(MRA_VEC_W'(free_vec)));
        open    = !req_v_q || rtr_req_ready;
        can_gnt = rst_n && open && (|free_vec);
        req_hs  = can_gnt && (|ch_req_valid);
        ch_req_ready = can_gnt ? gnt : '0;
    end

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (ch_req_valid),
        .en        (req_hs),
        .prio_mask (prio_mask),
        .gnt       (gnt),
        .gnt_idx   (win)
    );

    always_comb begin
        rsp_ent = tbl_q[rtr_rsp_id];
        rsp_hit = rst_n && rtr_rsp_valid && rsp_ent.vld;
        rsp_bad = rst_n && rtr_rsp_valid && !rsp_ent.vld;
        for (int c = 0; c < N_CH; c++) begin
            ch_rsp_valid[c] = rsp_hit && (rsp_ent.src == SRC_W'(c));
        end
        rtr_rsp_ready = rsp_bad || (|(ch_rsp_valid & ch_rsp_ready));
        ch_rsp_tag    = rsp_hit ? rsp_ent.tag : '0;
        ch_rsp_data   = rsp_hit ? rtr_rsp_data : '0;
        rsp_hs        = rsp_hit && rtr_rsp_ready;
        err_d         = err_q || rsp_bad;
    end

    always_comb begin
        tbl_d = tbl_q;
        if (rsp_hs) tbl_d[rtr_rsp_id].vld = 1'b0;
        if (req_hs) begin
            tbl_d[slot].vld = 1'b1;
            tbl_d[slot].src = win;
            tbl_d[slot].tag = ch_req_tag[int'(win)*TAG_W +: TAG_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MAX_OUTST; s++) tbl_q[s] <= '0;
            err_q   <= 1'b0;
            req_v_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            id_q    <= '0;
        end else begin
            tbl_q <= tbl_d;
            err_q <= err_d;
            if (req_hs) begin
                req_v_q <= 1'b1;
                we_q    <= ch_req_we[win];
                addr_q  <= ch_req_addr[int'(win)*ADDR_W +: ADDR_W];
                wdata_q <= ch_req_wdata[int'(win)*DATA_W +: DATA_W];
                id_q    <= slot;
            end else if (rtr_req_ready) begin
                req_v_q <= 1'b0;
            end
        end
    end

    assign rtr_req_valid = req_v_q;
    assign rtr_req_we    = we_q;
    assign rtr_req_addr  = addr_q;
    assign rtr_req_wdata = wdata_q;
    assign rtr_req_id    = id_q;
    assign err_bad_id    = err_q;

endmodule

// File: tb/tb_mem_req_arbiter_n.sv
// Testbench for mem_req_arbiter_n: directed table, corner sequences
// and a randomized run against a behavioural model.
module tb_mem_req_arbiter_n;

    localparam int N  = 5;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int TW = 4;
    localparam int MO = 8;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    ch_req_valid, ch_req_ready, ch_req_we;
    logic [N*AW-1:0] ch_req_addr;
    logic [N*DW-1:0] ch_req_wdata;
    logic [N*TW-1:0] ch_req_tag;
    logic [N-1:0]    ch_rsp_valid, ch_rsp_ready;
    logic [TW-1:0]   ch_rsp_tag;
    logic [DW-1:0]   ch_rsp_data;
    logic            rtr_req_valid, rtr_req_ready, rtr_req_we;
    logic [AW-1:0]   rtr_req_addr;
    logic [DW-1:0]   rtr_req_wdata;
    logic [IW-1:0]   rtr_req_id;
    logic            rtr_rsp_valid, rtr_rsp_ready;
    logic [IW-1:0]   rtr_rsp_id;
    logic [DW-1:0]   rtr_rsp_data;
    logic            err_bad_id;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_n dut (
        .clk(clk), .rst_n(rst_n),
        .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready),
        .ch_req_we(ch_req_we), .ch_req_addr(ch_req_addr),
        .ch_req_wdata(ch_req_wdata), .ch_req_tag(ch_req_tag),
        .ch_rsp_valid(ch_rsp_valid), .ch_rsp_ready(ch_rsp_ready),
        .ch_rsp_tag(ch_rsp_tag), .ch_rsp_data(ch_rsp_data),
        .rtr_req_valid(rtr_req_valid), .rtr_req_ready(rtr_req_ready),
        .rtr_req_we(rtr_req_we), .rtr_req_addr(rtr_req_addr),
        .rtr_req_wdata(rtr_req_wdata), .rtr_req_id(rtr_req_id),
        .rtr_rsp_valid(rtr_rsp_valid), .rtr_rsp_ready(rtr_rsp_ready),
        .rtr_rsp_id(rtr_rsp_id), .rtr_rsp_data(rtr_rsp_data),
        .err_bad_id(err_bad_id)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0]  rv;
        logic        rr;
        logic        sv;
        logic [2:0]  sid;
        logic [4:0]  crr;
        logic [4:0]  e_rdy;
        logic        e_ov;
        logic [2:0]  e_id;
        logic [31:0] e_addr;
        logic [4:0]  e_csv;
        logic        e_srr;
        logic [3:0]  e_tag;
        logic        e_err;
    } vec_t;

    vec_t tbl [22];

    // Behavioural model state
    bit             m_vld [MO];
    int             m_src [MO];
    logic [TW-1:0]  m_tag [MO];
    int             m_ptr;
    bit             m_ov;
    int             m_oid;
    logic           m_owe;
    logic [AW-1:0]  m_oaddr;
    logic [DW-1:0]  m_owd;
    bit             m_err;

    function automatic int exp_winner(input logic [4:0] rq, input int p);
`ifdef MRA_PRIO_EN
        if (rq[0]) return 0;
        for (int k = 0; k < N; k++) begin
            int c = (p + k) % N;
            if (c != 0 && rq[c]) return c;
        end
`else
        for (int k = 0; k < N; k++) begin
            int c = (p + k) % N;
            if (rq[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < MO; s++) m_vld[s] = 0;
        m_ptr = 0;
        m_ov  = 0;
        m_err = 0;
    endtask

    task automatic model_cycle();
        bit         full, open_, e_srr;
        int         w, slot, id;
        logic [4:0] e_rdy, e_csv;
        full = 1;
        slot = -1;
        for (int s = 0; s < MO; s++) begin
            if (!m_vld[s]) begin
                full = 0;
                if (slot < 0) slot = s;
            end
        end
        open_ = !m_ov || rtr_req_ready;
        w = (open_ && !full) ? exp_winner(ch_req_valid, m_ptr) : -1;
        e_rdy = (w >= 0) ? 5'(1 << w) : 5'd0;
        chk("rnd_req_ready", DW'(ch_req_ready), DW'(e_rdy));
        chk("rnd_rtr_valid", DW'(rtr_req_valid), DW'(m_ov));
        if (m_ov) begin
            chk("rnd_rtr_id", DW'(rtr_req_id), DW'(m_oid));
            chk("rnd_rtr_addr", DW'(rtr_req_addr), DW'(m_oaddr));
            chk("rnd_rtr_we", DW'(rtr_req_we), DW'(m_owe));
            chk("rnd_rtr_wdata", rtr_req_wdata, m_owd);
        end
        id = int'(rtr_rsp_id);
        e_csv = '0;
        e_srr = 0;
        if (rtr_rsp_valid) begin
            if (m_vld[id]) begin
                e_csv = 5'(1 << m_src[id]);
                e_srr = ch_rsp_ready[m_src[id]];
            end else begin
                e_srr = 1;
            end
        end
        chk("rnd_rsp_valid", DW'(ch_rsp_valid), DW'(e_csv));
        chk("rnd_rsp_ready", DW'(rtr_rsp_ready), DW'(e_srr));
        if (e_csv != 0) begin
            chk("rnd_rsp_tag", DW'(ch_rsp_tag), DW'(m_tag[id]));
            chk("rnd_rsp_data", ch_rsp_data, rtr_rsp_data);
        end
        chk("rnd_err", DW'(err_bad_id), DW'(m_err));
        if (rtr_rsp_valid) begin
            if (m_vld[id]) begin
                if (e_srr) m_vld[id] = 0;
            end else begin
                m_err = 1;
            end
        end
        if (w >= 0) begin
            m_vld[slot] = 1;
            m_src[slot] = w;
            m_tag[slot] = ch_req_tag[w*TW +: TW];
            m_ov    = 1;
            m_oid   = slot;
            m_owe   = ch_req_we[w];
            m_oaddr = ch_req_addr[w*AW +: AW];
            m_owd   = ch_req_wdata[w*DW +: DW];
`ifdef MRA_PRIO_EN
            if (w != 0) m_ptr = (w + 1) % N;
`else
            m_ptr = (w + 1) % N;
`endif
        end else if (rtr_req_ready) begin
            m_ov = 0;
        end
    endtask

    task automatic randomize_inputs();
        int q[$];
        logic [DW-1:0] wd;
        ch_req_valid = 5'($urandom);
        ch_req_we    = 5'($urandom);
        ch_req_tag   = 20'($urandom);
        for (int c = 0; c < N; c++) begin
            ch_req_addr[c*AW +: AW] = $urandom;
            for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
            ch_req_wdata[c*DW +: DW] = wd;
        end
        for (int k = 0; k < 16; k++) wd[k*32 +: 32] = $urandom;
        rtr_rsp_data  = wd;
        rtr_req_ready = ($urandom_range(3) != 0);
        rtr_rsp_valid = $urandom_range(1) == 1;
        ch_rsp_ready  = 5'($urandom) | 5'($urandom);
        for (int s = 0; s < MO; s++) if (m_vld[s]) q.push_back(s);
        if (q.size() > 0 && $urandom_range(7) != 0)
            rtr_rsp_id = IW'(q[$urandom_range(q.size() - 1)]);
        else
            rtr_rsp_id = IW'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        ch_req_valid = '0;
        ch_rsp_ready = '1;
        rtr_req_ready = 1'b0;
        rtr_rsp_valid = 1'b0;
        rtr_rsp_id = '0;
        rtr_rsp_data = {16{32'hD00DF00D}};
        for (int c = 0; c < N; c++) begin
            ch_req_addr[c*AW +: AW] = 32'h0800 + 32'(c) * 32'h400;
            ch_req_tag[c*TW +: TW]  = 4'(c + 1);
            ch_req_we[c]            = (c % 2) == 1;
            ch_req_wdata[c*DW +: DW] = {16{32'hA000 + 32'(c)}};
        end

        tbl[0]  = '{5'b00100,1,0,0,5'b11111, 5'b00100,0,0,32'h0,   5'b00000,0,0,0};
        tbl[1]  = '{5'b00000,1,0,0,5'b11111, 5'b00000,1,0,32'h1000,5'b00000,0,0,0};
        tbl[2]  = '{5'b00000,1,1,0,5'b11111, 5'b00000,0,0,32'h0,   5'b00100,1,3,0};
        tbl[3]  = '{5'b11111,1,0,0,5'b11111, 5'b01000,0,0,32'h0,   5'b00000,0,0,0};
        tbl[4]  = '{5'b11111,1,0,0,5'b11111, 5'b10000,1,0,32'h1400,5'b00000,0,0,0};
        tbl[5]  = '{5'b11111,1,0,0,5'b11111, 5'b00001,1,1,32'h1800,5'b00000,0,0,0};
        tbl[6]  = '{5'b11111,1,0,0,5'b11111, 5'b00010,1,2,32'h0800,5'b00000,0,0,0};
        tbl[7]  = '{5'b11111,1,0,0,5'b11111, 5'b00100,1,3,32'h0C00,5'b00000,0,0,0};
        tbl[8]  = '{5'b11111,1,0,0,5'b11111, 5'b01000,1,4,32'h1000,5'b00000,0,0,0};
        tbl[9]  = '{5'b11111,1,0,0,5'b11111, 5'b10000,1,5,32'h1400,5'b00000,0,0,0};
        tbl[10] = '{5'b11111,1,0,0,5'b11111, 5'b00001,1,6,32'h1800,5'b00000,0,0,0};
        tbl[11] = '{5'b11111,1,0,0,5'b11111, 5'b00000,1,7,32'h0800,5'b00000,0,0,0};
        tbl[12] = '{5'b11111,1,1,5,5'b11111, 5'b00000,0,0,32'h0,   5'b01000,1,4,0};
        tbl[13] = '{5'b11111,1,0,0,5'b11111, 5'b00010,0,0,32'h0,   5'b00000,0,0,0};
        tbl[14] = '{5'b00000,0,0,0,5'b11111, 5'b00000,1,5,32'h0C00,5'b00000,0,0,0};
        tbl[15] = '{5'b00000,1,1,0,5'b11111, 5'b00000,1,5,32'h0C00,5'b01000,1,4,0};
        tbl[16] = '{5'b01000,1,1,5,5'b11101, 5'b01000,0,0,32'h0,   5'b00010,0,2,0};
        tbl[17] = '{5'b00000,1,1,5,5'b11101, 5'b00000,1,0,32'h1400,5'b00010,0,2,0};
        tbl[18] = '{5'b00000,1,1,5,5'b11101, 5'b00000,0,0,32'h0,   5'b00010,0,2,0};
        tbl[19] = '{5'b00000,1,1,5,5'b11111, 5'b00000,0,0,32'h0,   5'b00010,1,2,0};
        tbl[20] = '{5'b00000,1,1,5,5'b11111, 5'b00000,0,0,32'h0,   5'b00000,1,0,0};
        tbl[21] = '{5'b00000,1,0,0,5'b11111, 5'b00000,0,0,32'h0,   5'b00000,0,0,1};

        #1;
        chk("reset_rtr_valid", DW'(rtr_req_valid), '0);
        chk("reset_req_ready", DW'(ch_req_ready), '0);
        chk("reset_err", DW'(err_bad_id), '0);
        chk("reset_addr", DW'(rtr_req_addr), '0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifndef MRA_PRIO_EN
        for (int r = 0; r < 22; r++) begin
            ch_req_valid  = tbl[r].rv;
            rtr_req_ready = tbl[r].rr;
            rtr_rsp_valid = tbl[r].sv;
            rtr_rsp_id    = tbl[r].sid;
            ch_rsp_ready  = tbl[r].crr;
            #3;
            chk($sformatf("row%0d_req_ready", r), DW'(ch_req_ready), DW'(tbl[r].e_rdy));
            chk($sformatf("row%0d_rtr_valid", r), DW'(rtr_req_valid), DW'(tbl[r].e_ov));
            if (tbl[r].e_ov) begin
                chk($sformatf("row%0d_rtr_id", r), DW'(rtr_req_id), DW'(tbl[r].e_id));
                chk($sformatf("row%0d_rtr_addr", r), DW'(rtr_req_addr), DW'(tbl[r].e_addr));
            end
            chk($sformatf("row%0d_rsp_valid", r), DW'(ch_rsp_valid), DW'(tbl[r].e_csv));
            chk($sformatf("row%0d_rsp_ready", r), DW'(rtr_rsp_ready), DW'(tbl[r].e_srr));
            chk($sformatf("row%0d_rsp_tag", r), DW'(ch_rsp_tag), DW'(tbl[r].e_tag));
            chk($sformatf("row%0d_err", r), DW'(err_bad_id), DW'(tbl[r].e_err));
            @(posedge clk);
            #1;
        end

        // Mid-burst asynchronous reset with entries in flight
        ch_req_valid  = '1;
        rtr_req_ready = 1'b1;
        rtr_rsp_valid = 1'b0;
        @(posedge clk);
        #1;
        rtr_rsp_valid = 1'b1;
        rtr_rsp_id    = 3'd1;
        ch_rsp_ready  = '1;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_rtr_valid", DW'(rtr_req_valid), '0);
        chk("arst_req_ready", DW'(ch_req_ready), '0);
        chk("arst_rsp_valid", DW'(ch_rsp_valid), '0);
        chk("arst_rsp_ready", DW'(rtr_rsp_ready), '0);
        chk("arst_err", DW'(err_bad_id), '0);
        chk("arst_rtr_id", DW'(rtr_req_id), '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        chk("post_rst_rsp_valid", DW'(ch_rsp_valid), '0);
        chk("post_rst_rsp_drop", DW'(rtr_rsp_ready), DW'(1));
        chk("post_rst_req_ready", DW'(ch_req_ready), DW'(5'b00001));
        @(posedge clk);
        #1;
        rtr_rsp_valid = 1'b0;
        ch_req_valid  = '0;
        #2;
        chk("post_rst_err", DW'(err_bad_id), DW'(1));
`else
        // Channel 0 overrides a pointer parked at 3 and leaves it there
        rtr_req_ready = 1'b1;
        ch_req_valid  = 5'b00100;
        #3 chk("prio_first", DW'(ch_req_ready), DW'(5'b00100));
        @(posedge clk);
        #1 ch_req_valid = 5'b01001;
        #3 chk("prio_ch0_wins", DW'(ch_req_ready), DW'(5'b00001));
        @(posedge clk);
        #1 ch_req_valid = 5'b01010;
        #3 chk("prio_ptr_kept", DW'(ch_req_ready), DW'(5'b01000));
        @(posedge clk);
        #1 ch_req_valid = '0;
`endif

        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        for (int t = 0; t < 3000; t++) begin
            randomize_inputs();
            #3;
            model_cycle();
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter_n.md
Name: mem_req_arbiter_n

Overview:
- Parametrised successor to the fixed five-port memory request arbiter in the memory system.
- Merges N_CH client request channels (L1 I/D caches, L1 D-splus, TC FSM) onto one router-bound request channel.
- Tracks up to MAX_OUTST in-flight transactions and routes each router response back to its originating channel with the client's original tag.

Parameters:
N_CH, 5, number of client channels (≥2)
ADDR_W, 32, request address width
DATA_W, 512, line data width
TAG_W, 4, client tag width
MAX_OUTST, 8, in-flight transaction table depth (power of 2); ID_W = $clog2(MAX_OUTST)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ch_req_valid  in  N_CH  per-channel request valid
ch_req_ready  out  N_CH  per-channel request accepted
ch_req_we  in  N_CH  write enable per channel
ch_req_addr  in  N_CH*ADDR_W  request address, packed, channel 0 in LSBs
ch_req_wdata  in  N_CH*DATA_W  write data, packed
ch_req_tag  in  N_CH*TAG_W  client tag, packed
ch_rsp_valid  out  N_CH  response valid to channel
ch_rsp_ready  in  N_CH  channel accepts response
ch_rsp_tag  out  TAG_W  original tag, shared bus, qualified by ch_rsp_valid
ch_rsp_data  out  DATA_W  response data, shared bus
rtr_req_valid  out  1  request to router valid
rtr_req_ready  in  1  router accepts request
rtr_req_we  out  1  write enable
rtr_req_addr  out  ADDR_W  address
rtr_req_wdata  out  DATA_W  write data
rtr_req_id  out  ID_W  transaction ID, equal to table slot index
rtr_rsp_valid  in  1  router response valid
rtr_rsp_ready  out  1  arbiter accepts router response
rtr_rsp_id  in  ID_W  transaction ID of response
rtr_rsp_data  in  DATA_W  response data
err_bad_id  out  1  sticky: response received for a non-allocated ID

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - All outputs 0 (rtr_req_valid, ch_req_ready, ch_rsp_valid, err_bad_id, all buses).
  - Table valid bits cleared; RR pointer = 0.
- Request path (1-cycle latency):
  - Output register slot is "open" when !rtr_req_valid || rtr_req_ready.
  - Grant is issued only when the slot is open AND at least one table entry is free.
  - Winner is the first requesting channel at or after rr_ptr, wrapping modulo N_CH.
  - ch_req_ready is one-hot to the winner, combinational, and is 0 when the grant conditions are not met.
  - On handshake:
    - Allocate the lowest free slot and write {src=winner, tag}.
    - Load the output register with we/addr/wdata, rtr_req_id=slot, rtr_req_valid=1 on the next edge.
    - rr_ptr = winner+1, wrapping to 0 at N_CH.
  - rtr_req_valid with all payload holds stable until rtr_req_ready. Back-to-back issue is allowed: the slot stays open while rtr_req_ready=1.
- Table full: all ch_req_ready=0, rr_ptr unchanged, and no request is lost.
- Response path (combinational pass-through):
  - Look up entry[rtr_rsp_id].
  - If the entry is valid: ch_rsp_valid[src]=rtr_rsp_valid, ch_rsp_tag=entry.tag, ch_rsp_data=rtr_rsp_data, rtr_rsp_ready=ch_rsp_ready[src].
  - On handshake, clear entry valid at the next edge.
- Bad ID: if rtr_rsp_valid and the entry is invalid, set rtr_rsp_ready=1 (drop the response), assert no ch_rsp_valid, and set err_bad_id=1 until reset.
- Simultaneous alloc/free in one cycle:
  - The free vector is computed from registered state, so a slot freed this cycle is not reallocated until the next cycle.
  - Alloc and free never target the same slot.
- Reset mid-operation: all in-flight entries are discarded; no responses are forwarded after reset.

Optional Feature:
- Macro: MRA_PRIO_EN.
- Defined: channel 0 (TC FSM) has strict priority. When ch_req_valid[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated. Channels 1..N_CH-1 arbitrate round-robin among themselves.
- Undefined: pure round-robin over all N_CH channels, as described above.

Decomposition:
- Package mra_pkg holds:
  - Localparam defaults.
  - Typedef mra_entry_t {logic vld; logic [$clog2(N_CH)-1:0] src; logic [TAG_W-1:0] tag}.
  - Helper function first_free(), lowest set bit of a vector.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs req, en, prio_mask.
  - Outputs one-hot gnt and gnt_idx; holds the rotating pointer.

Test Plan:
- Single request: ch2 valid, addr 0x1000, tag 3. Expect: rtr_req_valid next cycle with id 0. Router response id 0 -> ch_rsp_valid[2]=1, tag 3, entry freed.
- Fairness: all 5 channels valid continuously, rtr_req_ready=1. Expect grants ordered 0,1,2,3,4,0,… with one grant per cycle.
- Table full: MAX_OUTST=8 requests issued with no responses. Expect the 9th stalled (all ch_req_ready=0). One response id 5 -> next grant allocates id 5.
- Backpressure: response for ch1 with ch_rsp_ready[1]=0 for 3 cycles. Expect rtr_rsp_ready=0 for those cycles, entry held, delivered on cycle 4. Concurrent ch3 request unaffected.
- Bad ID and reset: response id 6 with no allocation -> rtr_rsp_ready=1, no ch_rsp_valid, err_bad_id=1. Assert rst_n low mid-burst -> all outputs 0 asynchronously, table empty.
- With MRA_PRIO_EN: ch0 and ch3 valid, rr_ptr=3 -> ch0 granted; rr_ptr stays 3.
